// File: rtl/sram_bus_if_ot.sv
// sram_bus_if_ot: addr_ok/data_ok bus bridge with in-order outstanding transactions, posted writes and flush discard
module sram_bus_if_ot #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OT    = 4,
  parameter int POSTED_WR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                cpu_rvalid_o,
  output logic                stallreq_o,
  output logic                req_o,
  output logic                wr_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   din_o,
  output logic [DATA_W/8-1:0] ben_o,
  input  logic                addr_ok_i,
  input  logic                data_ok_i,
  input  logic [DATA_W-1:0]   dout_i
);
  localparam int PW = $clog2(MAX_OT);
  localparam int CW = $clog2(MAX_OT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [MAX_OT-1:0] disc_q, disc_d, rd_q, rd_d, ww_q, ww_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rvalid_q, rvalid_d;
  logic              posted, push, pop, own, done, rd_done;
  assign wr_o         = cpu_we_i;
  assign addr_o       = cpu_addr_i;
  assign din_o        = cpu_data_i;
  assign ben_o        = cpu_sel_i;
  assign cpu_data_o   = data_q;
  assign cpu_rvalid_o = rvalid_q;
  always_comb begin
    posted     = cpu_we_i & (POSTED_WR != 0);
    req_o      = cpu_ce_i & (state_q == IDLE) & (cnt_q < CW'(MAX_OT)) & ~flush_i;
    push       = req_o & addr_ok_i;
    pop        = data_ok_i & (cnt_q != '0);
    // while waiting, the only live wait-type entry in the FIFO is our own access
    own        = pop & ~disc_q[rp_q] & (rd_q[rp_q] | ww_q[rp_q]);
    done       = ~flush_i & ((push & posted) | ((state_q == WAIT) & own));
    rd_done    = done & (state_q == WAIT) & rd_q[rp_q];
    stallreq_o = cpu_ce_i & ~done & (state_q != HOLD);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wp_d       = push ? wp_q + PW'(1) : wp_q;
    rp_d       = pop ? rp_q + PW'(1) : rp_q;
    disc_d     = disc_q;
    rd_d       = rd_q;
    ww_d       = ww_q;
    if (push) begin
      disc_d[wp_q] = flush_i;
      rd_d[wp_q]   = ~cpu_we_i;
      ww_d[wp_q]   = cpu_we_i & ~posted;
    end
    if (flush_i) disc_d = '1;
    data_d     = rd_done ? dout_i : data_q;
    rvalid_d   = rd_done;
    state_d    = flush_i                           ? IDLE :
                 done                              ? (stall_i ? HOLD : IDLE) :
                 (state_q == IDLE && push)         ? WAIT :
                 (state_q == HOLD && !stall_i)     ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      disc_q   <= '0;
      rd_q     <= '0;
      ww_q     <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      disc_q   <= disc_d;
      rd_q     <= rd_d;
      ww_q     <= ww_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
    end
  end
  a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (rst) data_ok_i |-> cnt_q != '0);
endmodule

// File: tb/tb_sram_bus_if_ot.sv
// tb_sram_bus_if_ot: directed checks of sram_bus_if_ot with immediate assertions
module tb_sram_bus_if_ot;
  logic        clk = 0, rst = 1, stall_i = 0, flush_i = 0;
  logic        cpu_ce_i = 0, cpu_we_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, dout_i = 0;
  logic [3:0]  cpu_sel_i = 4'hf;
  logic [31:0] cpu_data_o, addr_o, din_o;
  logic        cpu_rvalid_o, stallreq_o, req_o, wr_o;
  logic [3:0]  ben_o;
  logic        addr_ok_i = 0, data_ok_i = 0;
  int          n_chk = 0, n_fail = 0;

  sram_bus_if_ot dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .cpu_rvalid_o(cpu_rvalid_o), .stallreq_o(stallreq_o), .req_o(req_o),
    .wr_o(wr_o), .addr_o(addr_o), .din_o(din_o), .ben_o(ben_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tick(); tick();
    rst = 0; settle();
    chk("rst_req", req_o, 0);
    chk("rst_rvalid", cpu_rvalid_o, 0);
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_data", cpu_data_o, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    tick();
    // 1: single read
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h100; addr_ok_i = 1; settle();
    chk("t1_c0_req", req_o, 1);
    chk("t1_c0_stall", stallreq_o, 1);
    chk("t1_c0_addr", addr_o, 32'h100);
    tick();
    addr_ok_i = 0; settle();
    chk("t1_c1_req", req_o, 0);
    chk("t1_c1_stall", stallreq_o, 1);
    chk("t1_c1_cnt", dut.cnt_q, 1);
    tick(); settle();
    chk("t1_c2_stall", stallreq_o, 1);
    tick();
    data_ok_i = 1; dout_i = 32'hDEADBEEF; settle();
    chk("t1_c3_stall", stallreq_o, 0);
    chk("t1_c3_rvalid", cpu_rvalid_o, 0);
    tick();
    data_ok_i = 0; cpu_ce_i = 0; settle();
    chk("t1_c4_rvalid", cpu_rvalid_o, 1);
    chk("t1_c4_data", cpu_data_o, 32'hDEADBEEF);
    chk("t1_c4_cnt", dut.cnt_q, 0);
    tick(); settle();
    chk("t1_c5_rvalid", cpu_rvalid_o, 0);
    chk("t1_c5_data", cpu_data_o, 32'hDEADBEEF);
    // 2: posted writes fill the FIFO
    cpu_ce_i = 1; cpu_we_i = 1; addr_ok_i = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr_i = 32'h200 + 32'(4 * i); settle();
      chk("t2_wr_req", req_o, 1);
      chk("t2_wr_stall", stallreq_o, 0);
      tick();
    end
    settle();
    chk("t2_full_cnt", dut.cnt_q, 4);
    chk("t2_full_req", req_o, 0);
    chk("t2_full_stall", stallreq_o, 1);
    tick();
    data_ok_i = 1; settle();
    chk("t2_pop_req", req_o, 0);
    chk("t2_pop_stall", stallreq_o, 1);
    tick();
    data_ok_i = 0; settle();
    chk("t2_after_cnt", dut.cnt_q, 3);
    chk("t2_after_req", req_o, 1);
    chk("t2_after_stall", stallreq_o, 0);
    tick();
    cpu_ce_i = 0; addr_ok_i = 0; data_ok_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_drain_rvalid", cpu_rvalid_o, 0);
      tick();
    end
    data_ok_i = 0; settle();
    chk("t2_drain_cnt", dut.cnt_q, 0);
    chk("t2_drain_data", cpu_data_o, 32'hDEADBEEF);
    tick();
    // 3: flush discards in-flight read
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h180; addr_ok_i = 1; settle();
    chk("t3_c0_req", req_o, 1);
    tick();
    addr_ok_i = 0; flush_i = 1; settle();
    chk("t3_c1_req", req_o, 0);
    chk("t3_c1_stall", stallreq_o, 1);
    tick();
    flush_i = 0; data_ok_i = 1; dout_i = 32'h12345678; settle();
    chk("t3_c2_cnt", dut.cnt_q, 1);
    chk("t3_c2_idle_req", req_o, 1);
    tick();
    data_ok_i = 0; cpu_ce_i = 0; settle();
    chk("t3_c3_rvalid", cpu_rvalid_o, 0);
    chk("t3_c3_data", cpu_data_o, 32'hDEADBEEF);
    chk("t3_c3_cnt", dut.cnt_q, 0);
    tick();
    // 4: push and pop in the same cycle
    cpu_ce_i = 1; cpu_we_i = 1; addr_ok_i = 1; tick(); tick();
    cpu_we_i = 0; cpu_addr_i = 32'h300; data_ok_i = 1; dout_i = 32'h11111111; settle();
    chk("t4_pre_cnt", dut.cnt_q, 2);
    chk("t4_req", req_o, 1);
    chk("t4_stall", stallreq_o, 1);
    tick();
    addr_ok_i = 0; dout_i = 32'h22222222; settle();
    chk("t4_same_cnt", dut.cnt_q, 2);
    chk("t4_w2_stall", stallreq_o, 1);
    tick();
    dout_i = 32'hCAFEF00D; settle();
    chk("t4_rd_cnt", dut.cnt_q, 1);
    chk("t4_silent_rvalid", cpu_rvalid_o, 0);
    chk("t4_rd_stall", stallreq_o, 0);
    tick();
    data_ok_i = 0; cpu_ce_i = 0; settle();
    chk("t4_rvalid", cpu_rvalid_o, 1);
    chk("t4_data", cpu_data_o, 32'hCAFEF00D);
    chk("t4_cnt", dut.cnt_q, 0);
    tick();
    // 5: completion under stall goes to HOLD
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h400; addr_ok_i = 1; stall_i = 1; tick();
    addr_ok_i = 0; data_ok_i = 1; dout_i = 32'hA5A5A5A5; settle();
    chk("t5_done_stall", stallreq_o, 0);
    tick();
    data_ok_i = 0; settle();
    chk("t5_h1_rvalid", cpu_rvalid_o, 1);
    chk("t5_h1_data", cpu_data_o, 32'hA5A5A5A5);
    chk("t5_h1_req", req_o, 0);
    chk("t5_h1_stall", stallreq_o, 0);
    tick(); settle();
    chk("t5_h2_req", req_o, 0);
    chk("t5_h2_stall", stallreq_o, 0);
    chk("t5_h2_rvalid", cpu_rvalid_o, 0);
    chk("t5_h2_data", cpu_data_o, 32'hA5A5A5A5);
    tick();
    stall_i = 0; settle();
    chk("t5_h3_req", req_o, 0);
    chk("t5_h3_stall", stallreq_o, 0);
    tick(); settle();
    chk("t5_idle_req", req_o, 1);
    chk("t5_idle_stall", stallreq_o, 1);
    tick();
    // 6: reset while waiting with cnt=3
    cpu_we_i = 1; addr_ok_i = 1; tick(); tick();
    cpu_we_i = 0; tick();
    addr_ok_i = 0; settle();
    chk("t6_cnt", dut.cnt_q, 3);
    chk("t6_stall", stallreq_o, 1);
    chk("t6_req", req_o, 0);
    rst = 1; tick();
    rst = 0; cpu_ce_i = 0; settle();
    chk("t6_rst_cnt", dut.cnt_q, 0);
    chk("t6_rst_req", req_o, 0);
    chk("t6_rst_stall", stallreq_o, 0);
    chk("t6_rst_rvalid", cpu_rvalid_o, 0);
    chk("t6_rst_data", cpu_data_o, 0);
    cpu_ce_i = 1; settle();
    chk("t6_idle_req", req_o, 1);
    chk("t6_idle_stall", stallreq_o, 1);
    tick();
    cpu_ce_i = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
